// File: rtl/operand_scoreboard.sv
// Register file with per-register pending-write counters and operand forwarding for an in-order issue stage.
// Operand resolve and issue_ready_o are combinational (0 cycles); issue stalls on hazard, counter saturation or flush.
module operand_scoreboard #(
  parameter int NREG     = 32,
  parameter int DW       = 32,
  parameter int NRD      = 2,
  parameter int NFWD     = 3,
  parameter int MAX_PEND = 3,
  localparam int AW      = $clog2(NREG),
  localparam int CW      = $clog2(MAX_PEND + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid_i,
  input  logic                 issue_we_i,
  input  logic [AW-1:0]        issue_waddr_i,
  output logic                 issue_ready_o,
  input  logic [NRD-1:0]       rd_en_i,
  input  logic [NRD*AW-1:0]    raddr_i,
  output logic [NRD*DW-1:0]    rdata_o,
  input  logic [NFWD-1:0]      fwd_we_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD*AW-1:0]   fwd_waddr_i,
  input  logic [NFWD*DW-1:0]   fwd_wdata_i,
  input  logic                 wb_we_i,
  input  logic [AW-1:0]        wb_waddr_i,
  input  logic [DW-1:0]        wb_wdata_i,
  input  logic                 flush_i,
  output logic [NREG-1:0]      busy_o,
  output logic                 err_o
);

  logic [DW-1:0] regs [NREG];
  logic [CW-1:0] pend [NREG];
  logic [NRD-1:0] hz;
  logic [NREG-1:0] inc_hit;
  logic [NREG-1:0] dec_hit;
  logic sat;
  logic accept_we;
  logic wb_dec;
  logic underflow;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_o[r] = (pend[r] != '0);
    end
  end

  // Operand resolution: youngest forwarding stage wins, then the commit port, then the array.
  always_comb begin
    logic [AW-1:0] a;
    logic          hit;
    rdata_o = '0;
    hz      = '0;
    for (int k = 0; k < NRD; k++) begin
      a   = raddr_i[k*AW +: AW];
      hit = 1'b0;
      if (rd_en_i[k] && a != '0) begin
        for (int s = 0; s < NFWD; s++) begin
          if (!hit && fwd_we_i[s] && fwd_waddr_i[s*AW +: AW] == a) begin
            hit = 1'b1;
            if (fwd_valid_i[s]) begin
              rdata_o[k*DW +: DW] = fwd_wdata_i[s*DW +: DW];
            end else begin
              hz[k] = 1'b1;
            end
          end
        end
        if (!hit) begin
          if (wb_we_i && wb_waddr_i == a) begin
            rdata_o[k*DW +: DW] = wb_wdata_i;
          end else begin
            rdata_o[k*DW +: DW] = regs[a];
            hz[k] = (pend[a] != '0);
          end
        end
      end
    end
  end

  always_comb begin
    sat           = issue_we_i && issue_waddr_i != '0 && pend[issue_waddr_i] == CW'(MAX_PEND);
    issue_ready_o = rst && !flush_i && !(|hz) && !sat;
    accept_we     = issue_valid_i && issue_ready_o && issue_we_i && issue_waddr_i != '0;
    wb_dec        = wb_we_i && wb_waddr_i != '0;
    for (int r = 0; r < NREG; r++) begin
      inc_hit[r] = accept_we && issue_waddr_i == AW'(r);
      dec_hit[r] = wb_dec && wb_waddr_i == AW'(r);
    end
    // A same-cycle increment cancels the decrement, so it cannot underflow.
    underflow = wb_dec && pend[wb_waddr_i] == '0 && !(accept_we && issue_waddr_i == wb_waddr_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
      err_o <= 1'b0;
    end else begin
      if (wb_dec) begin
        regs[wb_waddr_i] <= wb_wdata_i;
      end
      if (underflow) begin
        err_o <= 1'b1;
      end
      for (int r = 1; r < NREG; r++) begin
        if (flush_i) begin
          pend[r] <= '0;
        end else if (inc_hit[r] && !dec_hit[r]) begin
          pend[r] <= pend[r] + 1'b1;
        end else if (dec_hit[r] && !inc_hit[r] && pend[r] != '0) begin
          pend[r] <= pend[r] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_scoreboard.sv
// Directed bench for operand_scoreboard: forwarding, load-use, saturation, same-cycle events, flush, reset, r0.
module tb_operand_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_we, issue_ready;
  logic [4:0]  issue_waddr;
  logic [1:0]  rd_en;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [2:0]  fwd_we, fwd_valid;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush;
  logic [31:0] busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  operand_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid), .issue_we_i(issue_we), .issue_waddr_i(issue_waddr),
    .issue_ready_o(issue_ready),
    .rd_en_i(rd_en), .raddr_i(raddr), .rdata_o(rdata),
    .fwd_we_i(fwd_we), .fwd_valid_i(fwd_valid), .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
    .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
    .flush_i(flush), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_waddr = 0;
    rd_en = 0; raddr = 0;
    fwd_we = 0; fwd_valid = 0; fwd_waddr = 0; fwd_wdata = 0;
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    flush = 0;
  endtask

  task automatic issue_w(input logic [4:0] a);
    issue_valid = 1; issue_we = 1; issue_waddr = a;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1; wb_waddr = a; wb_wdata = d;
  endtask

  initial begin
    rst = 0;
    idle();
    #3;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ready", 64'(issue_ready), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    tick();
    rst = 1;

    // forwarding priority: EX beats MEM
    idle();
    issue_valid = 1;
    rd_en = 2'b01; raddr = {5'd0, 5'd5};
    fwd_we = 3'b011; fwd_valid = 3'b011;
    fwd_waddr = {5'd0, 5'd5, 5'd5};
    fwd_wdata = {32'h0, 32'h22, 32'h11};
    #1;
    check("fwd_prio_data", 64'(rdata[31:0]), 64'h11);
    check("fwd_prio_ready", 64'(issue_ready), 64'h1);
    fwd_we = 3'b010;
    #1;
    check("fwd_mem_data", 64'(rdata[31:0]), 64'h22);
    tick();

    // load-use on port 1
    idle();
    issue_valid = 1;
    rd_en = 2'b10; raddr = {5'd7, 5'd0};
    fwd_we = 3'b001; fwd_valid = 3'b000; fwd_waddr = {10'd0, 5'd7};
    #1;
    check("loaduse_stall", 64'(issue_ready), 64'h0);
    tick();
    fwd_valid = 3'b001; fwd_wdata = {64'h0, 32'hABCD};
    #1;
    check("loaduse_data", 64'(rdata[63:32]), 64'hABCD);
    check("loaduse_ready", 64'(issue_ready), 64'h1);
    tick();

    // pending writer not yet visible, then commit bypass and array readback
    idle();
    issue_w(5'd6);
    tick();
    idle();
    rd_en = 2'b01; raddr = {5'd0, 5'd6};
    #1;
    check("busy6", 64'(busy[6]), 64'h1);
    check("pend_hazard", 64'(issue_ready), 64'h0);
    wb(5'd6, 32'h1234);
    #1;
    check("wb_bypass_data", 64'(rdata[31:0]), 64'h1234);
    check("wb_bypass_ready", 64'(issue_ready), 64'h1);
    tick();
    wb_we = 0;
    #1;
    check("array_data", 64'(rdata[31:0]), 64'h1234);
    check("busy6_clr", 64'(busy[6]), 64'h0);

    // saturation of r3
    idle();
    for (int i = 0; i < 3; i++) begin
      issue_w(5'd3);
      #1;
      check("sat_accept", 64'(issue_ready), 64'h1);
      tick();
    end
    #1;
    check("sat_busy", 64'(busy[3]), 64'h1);
    check("sat_full", 64'(issue_ready), 64'h0);
    issue_valid = 0;
    wb(5'd3, 32'h33);
    tick();
    wb_we = 0;
    #1;
    check("sat_released", 64'(issue_ready), 64'h1);
    wb(5'd3, 32'h33);
    tick();
    tick();
    idle();
    #1;
    check("sat_drained", 64'(busy[3]), 64'h0);
    check("no_err_yet", 64'(err), 64'h0);

    // simultaneous increment and decrement on r9
    issue_w(5'd9);
    tick();
    issue_w(5'd9);
    wb(5'd9, 32'h99);
    #1;
    check("simul_ready", 64'(issue_ready), 64'h1);
    tick();
    idle();
    #1;
    check("simul_busy", 64'(busy[9]), 64'h1);
    wb(5'd9, 32'h99);
    tick();
    idle();
    #1;
    check("r9_drained", 64'(busy[9]), 64'h0);
    check("r9_no_err", 64'(err), 64'h0);
    wb(5'd4, 32'h44);
    tick();
    idle();
    #1;
    check("underflow_err", 64'(err), 64'h1);
    check("underflow_busy4", 64'(busy[4]), 64'h0);
    tick();
    check("err_sticky", 64'(err), 64'h1);

    // register 0
    issue_w(5'd0);
    wb(5'd0, 32'hFFFF);
    #1;
    check("r0_issue_ready", 64'(issue_ready), 64'h1);
    tick();
    idle();
    rd_en = 2'b01; raddr = {5'd0, 5'd0};
    #1;
    check("r0_busy", 64'(busy[0]), 64'h0);
    check("r0_read", 64'(rdata[31:0]), 64'h0);
    fwd_we = 3'b001; fwd_valid = 3'b001; fwd_waddr = 15'd0; fwd_wdata = {64'h0, 32'hDEAD};
    #1;
    check("r0_fwd_read", 64'(rdata[31:0]), 64'h0);

    // flush clears pending, array write still lands
    idle();
    issue_w(5'd2);
    tick();
    tick();
    #1;
    check("flush_pre_busy2", 64'(busy[2]), 64'h1);
    flush = 1;
    wb(5'd8, 32'h88);
    #1;
    check("flush_ready", 64'(issue_ready), 64'h0);
    tick();
    idle();
    #1;
    check("flush_busy", 64'(busy), 64'h0);
    rd_en = 2'b10; raddr = {5'd8, 5'd0};
    #1;
    check("flush_wb_data", 64'(rdata[63:32]), 64'h88);
    check("flush_wb_ready", 64'(issue_ready), 64'h1);

    // mid-stream reset
    idle();
    issue_w(5'd1);
    tick();
    issue_valid = 0; issue_we = 0;
    wb(5'd1, 32'h5555);
    tick();
    idle();
    rd_en = 2'b01; raddr = {5'd0, 5'd1};
    #1;
    check("pre_rst_r1", 64'(rdata[31:0]), 64'h5555);
    issue_w(5'd1);
    tick();
    #1;
    check("pre_rst_busy1", 64'(busy[1]), 64'h1);
    rst = 0;
    #1;
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_ready", 64'(issue_ready), 64'h0);
    check("midrst_err", 64'(err), 64'h0);
    tick();
    rst = 1;
    idle();
    rd_en = 2'b11; raddr = {5'd8, 5'd1};
    #1;
    check("post_rst_r1", 64'(rdata[31:0]), 64'h0);
    check("post_rst_r8", 64'(rdata[63:32]), 64'h0);
    check("post_rst_ready", 64'(issue_ready), 64'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
